// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a word count then that many LSB-first words into instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum word verified before releasing the CPU.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int WORD_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int MAX_WORDS    = 256,
  parameter int TIMEOUT_CYC  = 1 << 20
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load_req_n,
  input  logic              uart_rx_pin,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int BPW  = WORD_W / 8;
  localparam int BIW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WORD_W:0] MAX_EXT = (WORD_W + 1)'(MAX_WORDS);

  if ((WORD_W % 8) != 0) begin : g_bad_word_w
    $error("WORD_W must be a multiple of 8");
  end
  if (MAX_WORDS > (1 << ADDR_W)) begin : g_bad_max_words
    $error("MAX_WORDS must not exceed 2**ADDR_W");
  end

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  logic [1:0]        rx_sync_q;
  logic [2:0]        req_sync_q;
  rx_state_t         rx_state_q;
  logic [CW-1:0]     rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;

  state_t            state_q;
  logic [BIW-1:0]    byte_idx_q;
  logic [WORD_W-1:0] word_asm_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [TW-1:0]     to_cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              cpu_hold_q;
  logic              load_done_q;
  logic              load_err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q;
`endif

  logic              rx_s;
  logic              req_fall_s;
  logic              stop_tick_s;
  logic              rx_done_s;
  logic              rx_ferr_s;
  logic              last_byte_s;
  logic              loading_s;
  logic [WORD_W-1:0] word_full_s;
  logic [ADDR_W:0]   word_cnt_inc_s;

  assign rx_s           = rx_sync_q[1];
  assign req_fall_s     = req_sync_q[2] & ~req_sync_q[1];
  assign stop_tick_s    = (rx_state_q == R_STOP) && (rx_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign rx_done_s      = stop_tick_s & rx_s;
  assign rx_ferr_s      = stop_tick_s & ~rx_s;
  assign last_byte_s    = (byte_idx_q == BIW'(BPW - 1));
  // Bytes enter at the top and shift down, so the first (LSB) byte ends at bit 0.
  assign word_full_s    = WORD_W'({rx_shift_q, word_asm_q} >> 8);
  assign word_cnt_inc_s = word_cnt_q + (ADDR_W + 1)'(1);
`ifdef LOADER_CHECKSUM_EN
  assign loading_s = (state_q == S_CNT) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
  assign loading_s = (state_q == S_CNT) || (state_q == S_DATA);
`endif

  // Input synchronisers; both lines idle high so a reset never fakes an edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_sync_q  <= 2'b11;
      req_sync_q <= 3'b111;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rx_pin};
      req_sync_q <= {req_sync_q[1:0], load_req_n};
    end
  end

  // UART byte receiver: half-bit start qualification, then centre sampling.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      case (rx_state_q)
        R_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s) rx_state_q <= R_START;
        end
        R_START: begin
          if (rx_cnt_q == CW'(HALF - 1)) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_state_q <= rx_s ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        R_STOP: begin
          if (stop_tick_s) begin
            rx_cnt_q   <= '0;
            rx_state_q <= R_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  // Loader FSM with registered memory-write and status outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= '0;
      word_asm_q  <= '0;
      count_q     <= '0;
      word_cnt_q  <= '0;
      to_cnt_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (req_fall_s) begin
        state_q     <= S_CNT;
        cpu_hold_q  <= 1'b1;
        load_done_q <= 1'b0;
        load_err_q  <= 1'b0;
        word_cnt_q  <= '0;
        byte_idx_q  <= '0;
        to_cnt_q    <= '0;
      end else if (loading_s) begin
        if (rx_ferr_s) begin
          state_q <= S_ERR;
        end else if (rx_done_s) begin
          to_cnt_q   <= '0;
          word_asm_q <= word_full_s;
          if (!last_byte_s) begin
            byte_idx_q <= byte_idx_q + BIW'(1);
          end else begin
            byte_idx_q <= '0;
            case (state_q)
              S_CNT: begin
                count_q <= (ADDR_W + 1)'(word_full_s);
`ifdef LOADER_CHECKSUM_EN
                csum_q  <= word_full_s;
`endif
                if ({1'b0, word_full_s} > MAX_EXT) begin
                  state_q <= S_ERR;
                end else if (word_full_s == '0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q <= S_CSUM;
`else
                  state_q <= S_DONE;
`endif
                end else begin
                  state_q <= S_DATA;
                end
              end
              S_DATA: begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                mem_wdata_q <= word_full_s;
                word_cnt_q  <= word_cnt_inc_s;
`ifdef LOADER_CHECKSUM_EN
                csum_q      <= csum_q ^ word_full_s;
                if (word_cnt_inc_s == count_q) state_q <= S_CSUM;
`else
                if (word_cnt_inc_s == count_q) state_q <= S_DONE;
`endif
              end
`ifdef LOADER_CHECKSUM_EN
              S_CSUM: state_q <= (word_full_s == csum_q) ? S_DONE : S_ERR;
`endif
              default: state_q <= S_ERR;
            endcase
          end
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_q <= S_ERR;
        end else begin
          to_cnt_q <= to_cnt_q + TW'(1);
        end
      end else begin
        // Status lands one cycle after the transition, i.e. after the final write strobe.
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_DONE: begin
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b1;
          end
          S_ERR:  load_err_q <= 1'b1;
          default: state_q <= S_ERR;
        endcase
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes queued as words are sent, popped on mem_we.
module tb_uart_prog_loader;
  localparam int CPB = 8;
  localparam int WW  = 16;
  localparam int AW  = 8;
  localparam int MW  = 256;
  localparam int TO  = 400;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          load_req_n = 1'b1;
  logic          uart_rx_pin = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic          cpu_hold, load_done, load_err;
  logic [AW:0]   word_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+WW-1:0] exp_q[$];
  logic [AW+WW-1:0] mon_e;

  always #5 CLK = ~CLK;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .WORD_W(WW), .ADDR_W(AW), .MAX_WORDS(MW), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RESET(RESET), .load_req_n(load_req_n), .uart_rx_pin(uart_rx_pin),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .word_cnt(word_cnt));

  // Write monitor: every strobe must match the head of the scoreboard while the CPU is held.
  always @(negedge CLK) begin
    if (mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          n_bad++;
          $display("FAIL write_data: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   mem_addr, mem_wdata, mon_e[AW+WW-1:WW], mon_e[WW-1:0]);
        end
      end
      n_cmp++;
      if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_during_write: got hold=%b done=%b, required hold=1 done=0", cpu_hold, load_done);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx_pin = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      repeat (CPB) @(negedge CLK);
    end
    uart_rx_pin = stop_bit;
    repeat (CPB) @(negedge CLK);
    uart_rx_pin = 1'b1;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
  endtask

  task automatic pulse_req();
    @(negedge CLK);
    load_req_n = 1'b0;
    repeat (4) @(negedge CLK);
    load_req_n = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic wait_status(input int max_cyc, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (load_done || load_err) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #100;
    n_cmp++; if (mem_we !== 1'b0)    begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0)    begin n_bad++; $display("FAIL rst_addr: got %0h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0)   begin n_bad++; $display("FAIL rst_wdata: got %0h want 0", mem_wdata); end
    n_cmp++; if (cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL rst_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", load_done); end
    n_cmp++; if (load_err !== 1'b0)  begin n_bad++; $display("FAIL rst_err: got %b want 0", load_err); end
    n_cmp++; if (word_cnt !== '0)    begin n_bad++; $display("FAIL rst_wcnt: got %0d want 0", word_cnt); end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_idle_line();
    send_byte(8'h5A, 1'b1);
    send_byte(8'h00, 1'b0);
    uart_rx_pin = 1'b0;
    repeat (2) @(negedge CLK);
    uart_rx_pin = 1'b1;
    repeat (60) @(negedge CLK);
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL idle_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL idle_err: got %b want 0", load_err); end
    n_cmp++; if (word_cnt !== '0)   begin n_bad++; $display("FAIL idle_wcnt: got %0d want 0", word_cnt); end
  endtask

  task automatic test_load_basic();
    bit exp_t;
    pulse_req();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL basic_hold_on: got %b want 1", cpu_hold); end
    exp_q.push_back({8'd0, 16'h1234});
    exp_q.push_back({8'd1, 16'hABCD});
    exp_q.push_back({8'd2, 16'h0001});
    send_word(16'h0003);
    send_word(16'h1234);
    send_word(16'hABCD);
    send_word(16'h0001);
`ifdef LOADER_CHECKSUM_EN
    send_word(16'h0003 ^ 16'h1234 ^ 16'hABCD ^ 16'h0001);
`endif
    wait_status(400, exp_t);
    n_cmp++; if (exp_t)              begin n_bad++; $display("FAIL basic_timeout: no status within bound"); end
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", load_done); end
    n_cmp++; if (load_err !== 1'b0)  begin n_bad++; $display("FAIL basic_err: got %b want 0", load_err); end
    n_cmp++; if (cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL basic_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (word_cnt !== 9'd3)  begin n_bad++; $display("FAIL basic_wcnt: got %0d want 3", word_cnt); end
    n_cmp++; if (exp_q.size() != 0)  begin n_bad++; $display("FAIL basic_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_count_zero();
    bit exp_t;
    pulse_req();
    send_word(16'h0000);
`ifdef LOADER_CHECKSUM_EN
    send_word(16'h0000);
`endif
    wait_status(400, exp_t);
    n_cmp++; if (exp_t)              begin n_bad++; $display("FAIL zero_timeout: no status within bound"); end
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL zero_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (word_cnt !== '0)    begin n_bad++; $display("FAIL zero_wcnt: got %0d want 0", word_cnt); end
  endtask

  task automatic test_count_limits();
    bit exp_t;
    pulse_req();
    send_word(16'h0100);
    repeat (50) @(negedge CLK);
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL max_ok_err: got %b want 0", load_err); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL max_ok_hold: got %b want 1", cpu_hold); end
    pulse_req();
    send_word(16'h0101);
    wait_status(400, exp_t);
    n_cmp++; if (exp_t)              begin n_bad++; $display("FAIL over_timeout: no status within bound"); end
    n_cmp++; if (load_err !== 1'b1)  begin n_bad++; $display("FAIL over_err: got %b want 1", load_err); end
    n_cmp++; if (cpu_hold !== 1'b1)  begin n_bad++; $display("FAIL over_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL over_done: got %b want 0", load_done); end
  endtask

  task automatic test_timeout();
    bit exp_t;
    pulse_req();
    exp_q.push_back({8'd0, 16'h5A5A});
    send_word(16'h0002);
    send_word(16'h5A5A);
    repeat (TO - 60) @(negedge CLK);
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL to_early: got err=%b want 0", load_err); end
    wait_status(200, exp_t);
    n_cmp++; if (exp_t)              begin n_bad++; $display("FAIL to_bound: no status within bound"); end
    n_cmp++; if (load_err !== 1'b1)  begin n_bad++; $display("FAIL to_err: got %b want 1", load_err); end
    n_cmp++; if (word_cnt !== 9'd1)  begin n_bad++; $display("FAIL to_wcnt: got %0d want 1", word_cnt); end
    n_cmp++; if (cpu_hold !== 1'b1)  begin n_bad++; $display("FAIL to_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (exp_q.size() != 0)  begin n_bad++; $display("FAIL to_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_frame_err();
    bit exp_t;
    pulse_req();
    send_word(16'h0002);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b0);
    wait_status(200, exp_t);
    n_cmp++; if (exp_t)             begin n_bad++; $display("FAIL fe_bound: no status within bound"); end
    n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL fe_err: got %b want 1", load_err); end
    n_cmp++; if (word_cnt !== '0)   begin n_bad++; $display("FAIL fe_wcnt: got %0d want 0", word_cnt); end
    repeat (50) @(negedge CLK);
    pulse_req();
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL fe_clear: got err=%b want 0", load_err); end
    exp_q.push_back({8'd0, 16'hBEEF});
    send_word(16'h0001);
    send_word(16'hBEEF);
`ifdef LOADER_CHECKSUM_EN
    send_word(16'h0001 ^ 16'hBEEF);
`endif
    wait_status(400, exp_t);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL fe_rec_done: got %b want 1", load_done); end
    n_cmp++; if (word_cnt !== 9'd1)  begin n_bad++; $display("FAIL fe_rec_wcnt: got %0d want 1", word_cnt); end
    n_cmp++; if (cpu_hold !== 1'b0)  begin n_bad++; $display("FAIL fe_rec_hold: got %b want 0", cpu_hold); end
  endtask

  task automatic test_restart();
    bit exp_t;
    pulse_req();
    exp_q.push_back({8'd0, 16'h1111});
    send_word(16'h0003);
    send_word(16'h1111);
    pulse_req();
    n_cmp++; if (word_cnt !== '0)   begin n_bad++; $display("FAIL rs_wcnt_clr: got %0d want 0", word_cnt); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rs_hold: got %b want 1", cpu_hold); end
    exp_q.push_back({8'd0, 16'h2222});
    send_word(16'h0001);
    send_word(16'h2222);
`ifdef LOADER_CHECKSUM_EN
    send_word(16'h0001 ^ 16'h2222);
`endif
    wait_status(400, exp_t);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL rs_done: got %b want 1", load_done); end
    n_cmp++; if (word_cnt !== 9'd1)  begin n_bad++; $display("FAIL rs_wcnt: got %0d want 1", word_cnt); end
    n_cmp++; if (exp_q.size() != 0)  begin n_bad++; $display("FAIL rs_drain: got %0d pending want 0", exp_q.size()); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit exp_t;
    pulse_req();
    exp_q.push_back({8'd0, 16'h00F0});
    exp_q.push_back({8'd1, 16'h0F00});
    send_word(16'h0002);
    send_word(16'h00F0);
    send_word(16'h0F00);
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL cs_early_done: got %b want 0", load_done); end
    send_word(16'h0FF2);
    wait_status(400, exp_t);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL cs_good_done: got %b want 1", load_done); end
    n_cmp++; if (load_err !== 1'b0)  begin n_bad++; $display("FAIL cs_good_err: got %b want 0", load_err); end
    pulse_req();
    exp_q.push_back({8'd0, 16'h00F0});
    exp_q.push_back({8'd1, 16'h0F00});
    send_word(16'h0002);
    send_word(16'h00F0);
    send_word(16'h0F00);
    send_word(16'h0FF3);
    wait_status(400, exp_t);
    n_cmp++; if (load_err !== 1'b1)  begin n_bad++; $display("FAIL cs_bad_err: got %b want 1", load_err); end
    n_cmp++; if (cpu_hold !== 1'b1)  begin n_bad++; $display("FAIL cs_bad_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL cs_bad_done: got %b want 0", load_done); end
  endtask
`endif

  task automatic test_reset_midload();
    pulse_req();
    send_word(16'h0002);
    send_byte(8'h77, 1'b1);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL mr_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (word_cnt !== '0)   begin n_bad++; $display("FAIL mr_wcnt: got %0d want 0", word_cnt); end
    RESET = 1'b1;
    send_byte(8'h88, 1'b1);
    repeat (50) @(negedge CLK);
    n_cmp++; if (word_cnt !== '0)   begin n_bad++; $display("FAIL mr_no_write: got wcnt %0d want 0", word_cnt); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL mr_idle_hold: got %b want 0", cpu_hold); end
  endtask

  initial begin
    test_reset();
    test_idle_line();
    test_load_basic();
    test_count_zero();
    test_count_limits();
    test_timeout();
    test_frame_err();
    test_restart();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    repeat (10) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
